node_credit_injector: RTL and testbench

Per-node injection stage that feeds one input lane (c_data/c_vld/c_cred) of the 4:1 upstream mux toward the hub. It buffers 20-bit flits from the local core and launches them as single-cycle valid pulses, one credit per flit. A credit counter, replenished by c_cred pulses, guarantees the node never has more than INIT_CREDITS flits outstanding in the mux/hub path.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_flit_fifo.sv | 61 ++++++
 rtl/node_credit_injector.sv | 93 +++++++++
 tb/tb_node_credit_injector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the node injection path.
// FLIT_W          : flit width carried by every mux lane.
// LANES_PER_MUX   : number of node lanes feeding one upstream mux.
// MUX_FIFO_DEPTH  : flit buffering in the mux/hub path per mux.
// INIT_CREDITS    : default credits per node; INIT_CREDITS * active lanes
//                   must not exceed MUX_FIFO_DEPTH or the hub can overflow.
package noc_pkg;

  localparam int FLIT_W         = 20;
  localparam int LANES_PER_MUX  = 4;
  localparam int MUX_FIFO_DEPTH = 8;
  localparam int INIT_CREDITS   = 2;
  localparam int CRED_W         = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  // Net effect of one clock edge on the credit counter.
  typedef enum logic [1:0] {
    CRED_HOLD = 2'd0,
    CRED_TAKE = 2'd1,
    CRED_GIVE = 2'd2
  } cred_op_e;

  // True when a credit budget is safe for the shared mux/hub buffering.
  function automatic bit credits_fit(input int init_credits, input int active_lanes);
    return (init_credits * active_lanes) <= MUX_FIFO_DEPTH;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, wr_data: write wr_data at tail (ignored when full)
//   pop, rd_data : rd_data is the head entry; pop advances head (ignored when empty)
//   level        : occupancy 0..DEPTH
//   full, empty  : level == DEPTH / level == 0
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FLIT_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [FLIT_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/node_credit_injector.sv
// Per-node injection stage feeding one lane of the 4:1 upstream mux.
// Buffers core flits and launches them as single-cycle pulses, spending one
// credit per flit; c_cred pulses return credits.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   core_data/valid/ready : core push interface (push = valid & ready)
//   c_data, c_vld         : registered flit and one-cycle launch pulse to mux lane
//   c_cred                : one-cycle credit return from mux
//   credits               : current credit count
//   fifo_level            : local FIFO occupancy
//   cred_err              : sticky, credit returned while already at INIT_CREDITS
module node_credit_injector
  import noc_pkg::*;
#(
  parameter int FLIT_W       = noc_pkg::FLIT_W,
  parameter int DEPTH        = 8,
  parameter int INIT_CREDITS = noc_pkg::INIT_CREDITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] core_data,
  input  logic              core_valid,
  output logic              core_ready,
  output logic [FLIT_W-1:0] c_data,
  output logic              c_vld,
  input  logic              c_cred,
  output logic [3:0]        credits,
  output logic [3:0]        fifo_level,
  output logic              cred_err
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [3:0] CRED_MAX = 4'(INIT_CREDITS);

  logic              push;
  logic              launch;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FLIT_W-1:0] head;
  logic [LVL_W-1:0]  level;
  cred_op_e          cred_op;

  noc_flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (core_data),
    .pop     (launch),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign core_ready = !rst && !fifo_full;
  assign push       = core_valid && core_ready;
  // Launch depends only on registered state, so it never sees a same-cycle push.
  assign launch     = !fifo_empty && (credits != '0);
  assign fifo_level = 4'(level);

  // A launch and a return on the same edge cancel out.
  always_comb begin
    cred_op = CRED_HOLD;
    if (launch && !c_cred)      cred_op = CRED_TAKE;
    else if (c_cred && !launch) cred_op = CRED_GIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_data   <= '0;
      c_vld    <= 1'b0;
      credits  <= CRED_MAX;
      cred_err <= 1'b0;
    end else begin
      c_vld <= launch;
      if (launch) c_data <= head;
      case (cred_op)
        CRED_TAKE: credits <= credits - 1'b1;
        CRED_GIVE: begin
          // Saturate instead of wrapping; a surplus return means the hub
          // and this node disagree on outstanding flits.
          if (credits == CRED_MAX) cred_err <= 1'b1;
          else                     credits  <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_credit_injector.sv
module tb_node_credit_injector;

  localparam int W     = 20;
  localparam int DEPTH = 8;
  localparam int INIT  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] core_data = '0;
  logic         core_valid = 1'b0;
  logic         core_ready;
  logic [W-1:0] c_data;
  logic         c_vld;
  logic         c_cred = 1'b0;
  logic [3:0]   credits;
  logic [3:0]   fifo_level;
  logic         cred_err;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: queue of buffered flits, credit count, sticky error,
  // expected lane outputs.
  logic [W-1:0] m_q[$];
  int           m_cred;
  bit           m_err;
  bit           m_vld;
  logic [W-1:0] m_data;

  node_credit_injector #(.FLIT_W(W), .DEPTH(DEPTH), .INIT_CREDITS(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_data  (core_data),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .c_data     (c_data),
    .c_vld      (c_vld),
    .c_cred     (c_cred),
    .credits    (credits),
    .fifo_level (fifo_level),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_cred = INIT;
    m_err  = 1'b0;
    m_vld  = 1'b0;
    m_data = '0;
  endtask

  task automatic model_edge();
    bit do_launch, do_push;
    if (rst) begin
      model_reset();
      return;
    end
    do_launch = (m_q.size() != 0) && (m_cred != 0);
    do_push   = core_valid && (m_q.size() < DEPTH);
    m_vld = do_launch;
    if (do_launch) m_data = m_q.pop_front();
    if (do_push) m_q.push_back(core_data);
    if (do_launch && !c_cred) m_cred--;
    else if (c_cred && !do_launch) begin
      if (m_cred == INIT) m_err = 1'b1;
      else m_cred++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (core_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", core_ready); else n_pass++;
    n_checks++; if (credits !== 4'(INIT)) $display("FAIL rst_credits got %0d want %0d", credits, INIT); else n_pass++;
    n_checks++; if (c_vld !== 1'b0) $display("FAIL rst_vld got %b want 0", c_vld); else n_pass++;
    // Put some traffic in flight, then assert reset between edges.
    for (int i = 0; i < 3; i++) begin
      core_data = W'(32'h00F00 + i); core_valid = 1'b1; tick();
    end
    core_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (c_vld !== 1'b0) $display("FAIL async_rst_vld got %b want 0", c_vld); else n_pass++;
    n_checks++; if (credits !== 4'(INIT)) $display("FAIL async_rst_credits got %0d want %0d", credits, INIT); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL async_rst_level got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (core_ready !== 1'b0) $display("FAIL async_rst_ready got %b want 0", core_ready); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (core_ready !== 1'b1) $display("FAIL rst_deassert_ready got %b want 1", core_ready); else n_pass++;
  endtask

  task automatic test_single();
    core_data = 20'hA5A5A; core_valid = 1'b1; tick();
    core_valid = 1'b0;
    n_checks++; if (c_vld !== 1'b0) $display("FAIL single_no_early_vld got %b want 0", c_vld); else n_pass++;
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL single_level got %0d want 1", fifo_level); else n_pass++;
    tick();
    n_checks++; if (c_vld !== 1'b1) $display("FAIL single_vld got %b want 1", c_vld); else n_pass++;
    n_checks++; if (c_data !== 20'hA5A5A) $display("FAIL single_data got %h want a5a5a", c_data); else n_pass++;
    n_checks++; if (credits !== 4'd1) $display("FAIL single_credits got %0d want 1", credits); else n_pass++;
    tick();
    n_checks++; if (c_vld !== 1'b0) $display("FAIL single_pulse_width got %b want 0", c_vld); else n_pass++;
    c_cred = 1'b1; tick(); c_cred = 1'b0;
    n_checks++; if (credits !== 4'd2) $display("FAIL single_cred_return got %0d want 2", credits); else n_pass++;
  endtask

  task automatic test_credit_stall();
    logic [W-1:0] seen[$];
    int pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      core_valid = (i <= 4);
      core_data  = W'(i);
      tick();
      if (c_vld === 1'b1) begin pulses++; seen.push_back(c_data); end
    end
    core_valid = 1'b0;
    n_checks++; if (pulses != 2) $display("FAIL stall_pulse_count got %0d want 2", pulses); else n_pass++;
    n_checks++; if (seen.size() < 2 || seen[0] !== 20'h00001 || seen[1] !== 20'h00002)
      $display("FAIL stall_order got %p want 1,2", seen); else n_pass++;
    n_checks++; if (credits !== 4'd0) $display("FAIL stall_credits got %0d want 0", credits); else n_pass++;
    n_checks++; if (fifo_level !== 4'd2) $display("FAIL stall_level got %0d want 2", fifo_level); else n_pass++;
    n_checks++; if (c_vld !== 1'b0) $display("FAIL stall_idle_vld got %b want 0", c_vld); else n_pass++;
    c_cred = 1'b1; tick(); c_cred = 1'b0;
    n_checks++; if (credits !== 4'd1) $display("FAIL stall_cred_in got %0d want 1", credits); else n_pass++;
    tick();
    n_checks++; if (c_vld !== 1'b1 || c_data !== 20'h00003)
      $display("FAIL stall_resume got vld=%b data=%h want vld=1 data=00003", c_vld, c_data); else n_pass++;
    c_cred = 1'b1; tick(); c_cred = 1'b0; tick();
    n_checks++; if (c_vld !== 1'b1 || c_data !== 20'h00004)
      $display("FAIL stall_last got vld=%b data=%h want vld=1 data=00004", c_vld, c_data); else n_pass++;
    n_checks++; if (credits !== 4'd0 || fifo_level !== 4'd0)
      $display("FAIL stall_end got cred=%0d lvl=%0d want 0/0", credits, fifo_level); else n_pass++;
  endtask

  // Enters with credits=0 so the FIFO can be filled completely.
  task automatic test_full();
    logic [W-1:0] seen[$];
    bit order_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      core_data = W'(32'h100 + i); core_valid = 1'b1; tick();
    end
    n_checks++; if (fifo_level !== 4'(DEPTH)) $display("FAIL full_level got %0d want %0d", fifo_level, DEPTH); else n_pass++;
    n_checks++; if (core_ready !== 1'b0) $display("FAIL full_ready got %b want 0", core_ready); else n_pass++;
    core_data = 20'h00BAD; tick();
    core_valid = 1'b0;
    n_checks++; if (fifo_level !== 4'(DEPTH)) $display("FAIL full_reject got %0d want %0d", fifo_level, DEPTH); else n_pass++;
    c_cred = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      if (c_vld === 1'b1) seen.push_back(c_data);
    end
    c_cred = 1'b0;
    n_checks++; if (seen.size() != DEPTH) $display("FAIL full_drain_count got %0d want %0d", seen.size(), DEPTH); else n_pass++;
    foreach (seen[k]) if (seen[k] !== W'(32'h100 + k)) order_ok = 1'b0;
    n_checks++; if (!order_ok) $display("FAIL full_drain_order got %p want 100..107", seen); else n_pass++;
    n_checks++; if (credits !== 4'd1 || fifo_level !== 4'd0)
      $display("FAIL full_end got cred=%0d lvl=%0d want 1/0", credits, fifo_level); else n_pass++;
    c_cred = 1'b1; tick(); c_cred = 1'b0;
  endtask

  task automatic test_simultaneous();
    core_data = 20'h11111; core_valid = 1'b1; tick();
    core_valid = 1'b0; tick();
    n_checks++; if (credits !== 4'd1) $display("FAIL simul_setup got %0d want 1", credits); else n_pass++;
    core_data = 20'h22222; core_valid = 1'b1; tick();
    core_data = 20'h33333; c_cred = 1'b1; tick();
    core_valid = 1'b0; c_cred = 1'b0;
    n_checks++; if (credits !== 4'd1) $display("FAIL simul_cred_cancel got %0d want 1", credits); else n_pass++;
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL simul_push_pop_level got %0d want 1", fifo_level); else n_pass++;
    n_checks++; if (c_vld !== 1'b1 || c_data !== 20'h22222)
      $display("FAIL simul_launch got vld=%b data=%h want 1/22222", c_vld, c_data); else n_pass++;
    tick();
    n_checks++; if (c_data !== 20'h33333 || credits !== 4'd0)
      $display("FAIL simul_next got data=%h cred=%0d want 33333/0", c_data, credits); else n_pass++;
    c_cred = 1'b1; tick(); tick(); c_cred = 1'b0;
    n_checks++; if (credits !== 4'd2) $display("FAIL simul_restore got %0d want 2", credits); else n_pass++;
  endtask

  task automatic test_overflow_reset();
    c_cred = 1'b1; tick(); c_cred = 1'b0;
    n_checks++; if (credits !== 4'd2) $display("FAIL ovf_saturate got %0d want 2", credits); else n_pass++;
    n_checks++; if (cred_err !== 1'b1) $display("FAIL ovf_err got %b want 1", cred_err); else n_pass++;
    tick(); tick();
    n_checks++; if (cred_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", cred_err); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      core_data = W'(32'h7000 + i); core_valid = 1'b1; tick();
    end
    core_valid = 1'b0;
    rst = 1'b1; c_cred = 1'b1;
    model_reset();
    #1;
    n_checks++; if (cred_err !== 1'b0 || fifo_level !== 4'd0 || credits !== 4'(INIT) || c_vld !== 1'b0)
      $display("FAIL midrst got err=%b lvl=%0d cred=%0d vld=%b want 0/0/%0d/0", cred_err, fifo_level, credits, c_vld, INIT);
    else n_pass++;
    tick();
    c_cred = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++; if (credits !== 4'(INIT) || cred_err !== 1'b0)
      $display("FAIL rst_cred_ignored got cred=%0d err=%b want %0d/0", credits, cred_err, INIT); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int vprob, cprob;
      vprob = (cyc < 300) ? 7 : 3;
      cprob = (cyc < 300) ? 4 : 2;
      core_valid = ($urandom_range(0, 9) < vprob);
      core_data  = W'($urandom);
      c_cred     = (m_cred < INIT) && ($urandom_range(0, cprob - 1) == 0);
      tick();
      n_checks++; if (c_vld !== m_vld) begin errs++; $display("FAIL rand_vld cyc=%0d got %b want %b", cyc, c_vld, m_vld); end else n_pass++;
      n_checks++; if (c_data !== m_data) begin errs++; $display("FAIL rand_data cyc=%0d got %h want %h", cyc, c_data, m_data); end else n_pass++;
      n_checks++; if (credits !== 4'(m_cred)) begin errs++; $display("FAIL rand_credits cyc=%0d got %0d want %0d", cyc, credits, m_cred); end else n_pass++;
      n_checks++; if (fifo_level !== 4'(m_q.size())) begin errs++; $display("FAIL rand_level cyc=%0d got %0d want %0d", cyc, fifo_level, m_q.size()); end else n_pass++;
      n_checks++; if (core_ready !== (m_q.size() < DEPTH)) begin errs++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, core_ready, m_q.size() < DEPTH); end else n_pass++;
      n_checks++; if (cred_err !== m_err) begin errs++; $display("FAIL rand_err cyc=%0d got %b want %b", cyc, cred_err, m_err); end else n_pass++;
      if (errs > 20) break;
    end
    core_valid = 1'b0;
    c_cred = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_full();
    test_simultaneous();
    test_overflow_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
